// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32 M-extension sequencer: operand width,
// funct3 opcodes and FSM state encoding.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    assign shifted = {rem_i[XLEN-1:0], bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

    // A set top remainder bit means the shifted value certainly exceeds the divisor.
    assign q_o   = rem_i[XLEN] | ~diff[XLEN+1];
    assign rem_o = q_o ? diff[XLEN:0] : shifted;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/REM sequencer for the EX stage: registered multiplier,
// iterative restoring divider, pipeline stall and one-cycle done pulse.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_e          state_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   rem_q;
    logic [4:0]      cnt_q;
    logic            negQ_q;
    logic            negR_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            isSigned;
    logic            divZero;
    logic            divOvf;
    logic [XLEN-1:0] absA;
    logic [XLEN-1:0] absB;
    logic [XLEN-1:0] special_d;

    assign accept    = (state_q == S_IDLE) & start_i & ~kill_i;
    assign isSigned  = ~funct3_i[0];
    assign divZero   = (rs2_i == '0);
    assign divOvf    = isSigned & (rs1_i == 32'h8000_0000) & (rs2_i == '1);
    assign absA      = (isSigned & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign absB      = (isSigned & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    assign special_d = divZero ? (funct3_i[1] ? rs1_i : '1)
                               : (funct3_i[1] ? '0 : 32'h8000_0000);

    // Operands are sign- or zero-extended to 33 bits; bits [63:0] of their product suffice.
    logic            signA;
    logic            signB;
    logic [63:0]     mulA;
    logic [63:0]     mulB;
    logic [63:0]     prod_d;
    logic [XLEN-1:0] mulRes_d;

    assign signA    = (op_q == F3_MULH) | (op_q == F3_MULHSU);
    assign signB    = (op_q == F3_MULH);
    assign mulA     = {{32{signA & a_q[XLEN-1]}}, a_q};
    assign mulB     = {{32{signB & b_q[XLEN-1]}}, b_q};
    assign prod_d   = mulA * mulB;
    assign mulRes_d = (op_q == F3_MUL) ? prod_d[31:0] : prod_d[63:32];

    logic [XLEN:0]   stepRem_d;
    logic            stepQ_d;
    logic [XLEN-1:0] quoFix_d;
    logic [XLEN-1:0] remFix_d;

    div_step u_divStep (
        .rem_i     (rem_q),
        .divisor_i (b_q),
        .bit_i     (a_q[XLEN-1]),
        .rem_o     (stepRem_d),
        .q_o       (stepQ_d)
    );

    assign quoFix_d = negQ_q ? -a_q : a_q;
    assign remFix_d = negR_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    // During DIV, a_q shifts dividend bits out the top and quotient bits in the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q <= funct3_i;
                        if (!funct3_i[2]) begin
                            a_q     <= rs1_i;
                            b_q     <= rs2_i;
                            state_q <= S_MUL;
                        end else if (divZero | divOvf) begin
                            result_q <= special_d;
                            state_q  <= S_DONE;
                        end else begin
                            a_q     <= absA;
                            b_q     <= absB;
                            rem_q   <= '0;
                            cnt_q   <= 5'd31;
                            negQ_q  <= isSigned & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                            negR_q  <= isSigned & rs1_i[XLEN-1];
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_q <= mulRes_d;
                    state_q  <= S_DONE;
                end
                S_DIV: begin
                    rem_q <= stepRem_d;
                    a_q   <= {a_q[XLEN-2:0], stepQ_d};
                    if (cnt_q == 5'd0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_FIX: begin
                    result_q <= op_q[1] ? remFix_d : quoFix_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = accept | (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected results and
// latencies, checked when done_o fires.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    int          latQ[$];
    logic [31:0] lastRes;
    bit          pokeStart;

    muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from 64-bit integer arithmetic plus the RISC-V special cases.
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        r  = '0;
        case (f3)
            F3_MUL:    begin p = sa * sb; r = p[31:0];  end
            F3_MULH:   begin p = sa * sb; r = p[63:32]; end
            F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            F3_DIVU: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            F3_REM: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Called at a falling edge while the DUT is idle; returns just after the accept edge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input bit expectDone);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        start_i  = 1'b1;
        #1;
        checkOutput("stall_req", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        if (expectDone) begin
            expQ.push_back(refResult(f3, a, b));
            latQ.push_back(refLatency(f3, a, b));
        end
    endtask

    task automatic waitDone();
        logic [31:0] expRes;
        int          expLat;
        int          k;
        bit          seen;
        bit          stallBad;
        if (expQ.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
            return;
        end
        expRes   = expQ.pop_front();
        expLat   = latQ.pop_front();
        k        = 0;
        seen     = 1'b0;
        stallBad = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (pokeStart && k == 2) begin
                start_i  = 1'b1;
                funct3_i = F3_MUL;
                rs1_i    = 32'd3;
                rs2_i    = 32'd5;
            end
            if (k == 3) start_i = 1'b0;
            if (done_o) seen = 1'b1;
            else if (!stall_o) stallBad = 1'b1;
        end
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", 32'(k), 32'(expLat));
        checkOutput("stall_hold", 32'(stallBad), 32'd0);
        checkOutput("result", result_o, expRes);
        checkOutput("stall_done", 32'(stall_o), 32'd0);
        lastRes = expRes;
        @(negedge clk);
        checkOutput("done_pulse", 32'(done_o), 32'd0);
        checkOutput("result_hold", result_o, expRes);
    endtask

    initial begin
        bit          sawDone;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        start_i   = 1'b0;
        kill_i    = 1'b0;
        funct3_i  = '0;
        rs1_i     = '0;
        rs2_i     = '0;
        pokeStart = 1'b0;
        lastRes   = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_result", result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(F3_MULH, 32'hFFFF_FFFF, 32'd2, 1'b1);
        waitDone();

        pokeStart = 1'b1;
        applyStimulus(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDone();
        pokeStart = 1'b0;
        applyStimulus(F3_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDone();

        applyStimulus(F3_DIVU, 32'd100, 32'd0, 1'b1);
        waitDone();
        applyStimulus(F3_REMU, 32'd100, 32'd0, 1'b1);
        waitDone();

        applyStimulus(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone();
        applyStimulus(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone();

        // Kill during a divide: back to idle, no done, result untouched, restart accepted.
        applyStimulus(F3_DIVU, 32'd1000, 32'd7, 1'b0);
        sawDone = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done_o) sawDone = 1'b1;
            if (k == 10) kill_i = 1'b1;
        end
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        @(negedge clk);
        checkOutput("kill_busy", 32'(busy_o), 32'd0);
        checkOutput("kill_done", 32'(done_o | sawDone), 32'd0);
        checkOutput("kill_stall", 32'(stall_o), 32'd0);
        checkOutput("kill_result", result_o, lastRes);
        applyStimulus(F3_DIVU, 32'd1000, 32'd7, 1'b1);
        waitDone();

        // Asynchronous reset in the middle of a divide.
        applyStimulus(F3_DIV, 32'd50, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_stall", 32'(stall_o), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("mid_rst_done", 32'(done_o), 32'd0);
        checkOutput("mid_rst_result", result_o, 32'd0);
        lastRes = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        waitDone();

        for (int i = 0; i < 16; i++) begin
            rf3 = 3'($urandom_range(7, 0));
            ra  = $urandom;
            if (i % 5 == 4) rb = 32'd0;
            else if (i % 3 == 0) rb = 32'($urandom_range(20, 1));
            else rb = $urandom;
            applyStimulus(rf3, ra, rb, 1'b1);
            waitDone();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
